// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
//
// Per-phase countdown timer for the traffic-light controller. The 1 Hz
// clk_mstr square wave is synchronized into the 50 MHz domain, and each
// detected rising edge becomes a one-second tick. The ticks count down a
// loadable phase duration. A single-cycle expired pulse marks the end of a
// phase. The timer also supports hold (pause) and reload.
//
// Ports:
//   clk_50_mhz  in   1         system clock; all logic is on its rising edge
//   reset_n     in   1         synchronous, active-low reset
//   clk_mstr    in   1         1 Hz square wave (asynchronous)
//   load        in   1         one-cycle request to start a phase
//   duration    in   SEC_BITS  phase length in seconds, sampled with load
//   pause       in   1         level; while high, ticks do not decrement
//   tick        out  1         one-cycle pulse per detected clk_mstr rise
//   busy        out  1         high while a phase is counting or held
//   remaining   out  SEC_BITS  seconds left in the current phase
//   expired     out  1         one-cycle pulse when the phase reaches 0
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int SEC_BITS    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_50_mhz,
    input  logic                reset_n,
    input  logic                clk_mstr,
    input  logic                load,
    input  logic [SEC_BITS-1:0] duration,
    input  logic                pause,
    output logic                tick,
    output logic                busy,
    output logic [SEC_BITS-1:0] remaining,
    output logic                expired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [SEC_BITS-1:0] SEC_ZERO = '0;
    localparam logic [SEC_BITS-1:0] SEC_ONE  = {{(SEC_BITS-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick_q;
    logic                   edge_s;

    state_e                 state_q, state_d;
    logic [SEC_BITS-1:0]    rem_q, rem_d;
    logic                   exp_q, exp_d;
    logic                   busy_q, busy_d;

    // The rising edge is seen one stage past the synchronizer, so the
    // counting logic acts on the same clock edge that raises tick.
    assign edge_s = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Synchronizer chain, edge history flop and registered tick pulse.
    always_ff @(posedge clk_50_mhz) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_mstr};
            hist_q <= sync_q[SYNC_STAGES-1];
            tick_q <= edge_s;
        end
    end

    // FSM state, countdown value and registered status outputs.
    always_ff @(posedge clk_50_mhz) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            rem_q   <= SEC_ZERO;
            exp_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: load wins over an edge, pause freezes the count, and
    // edges seen while held are dropped rather than replayed.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;

        if (load) begin
            if (duration != SEC_ZERO) begin
                rem_d   = duration;
                state_d = ST_RUN;
            end else begin
                // A zero-length phase ends immediately.
                rem_d   = SEC_ZERO;
                exp_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_HOLD;
                    end else if (edge_s) begin
                        if (rem_q == SEC_ONE) begin
                            rem_d   = SEC_ZERO;
                            exp_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else if (rem_q != SEC_ZERO) begin
                            rem_d   = rem_q - SEC_ONE;
                            state_d = ST_RUN;
                        end else begin
                            // The count is never 0 in RUN, but do not wrap if it is.
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    // Recover from an illegal encoding without a spurious expiry.
                    state_d = ST_IDLE;
                    rem_d   = SEC_ZERO;
                end
            endcase
        end
    end

    // busy is registered from the next state, so it falls together with expired.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    assign tick      = tick_q;
    assign busy      = busy_q;
    assign remaining = rem_q;
    assign expired   = exp_q;

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer. A behavioural model predicts the
// outputs from the timer's rules: a tick follows a sampled clk_mstr rise
// after a fixed sample delay, and the count drops by one per tick while the
// phase is active and not held. Directed scenarios and a randomized run are
// both compared against this model on every clock.
module tb_phase_timer;

    localparam int SB = 6;
    localparam int SS = 2;

    logic          clk_50_mhz = 1'b0;
    logic          reset_n    = 1'b0;
    logic          clk_mstr   = 1'b0;
    logic          load       = 1'b0;
    logic [SB-1:0] duration   = '0;
    logic          pause      = 1'b0;
    logic          tick;
    logic          busy;
    logic [SB-1:0] remaining;
    logic          expired;

    int n_chk  = 0;
    int n_pass = 0;
    int n_tick = 0;
    int n_exp  = 0;

    // Model state.
    bit samp[$];          // clk_mstr samples, newest first
    bit m_tick, m_busy, m_exp;
    int m_rem;
    bit prev_pause, prev_load;

    phase_timer #(.SEC_BITS(SB), .SYNC_STAGES(SS)) dut (
        .clk_50_mhz (clk_50_mhz),
        .reset_n    (reset_n),
        .clk_mstr   (clk_mstr),
        .load       (load),
        .duration   (duration),
        .pause      (pause),
        .tick       (tick),
        .busy       (busy),
        .remaining  (remaining),
        .expired    (expired)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit ev;
        bit run_now;
        if (!reset_n) begin
            m_tick = 1'b0; m_busy = 1'b0; m_rem = 0; m_exp = 1'b0;
            prev_pause = 1'b0; prev_load = 1'b0;
            samp.delete();
            for (int i = 0; i <= SS; i++) samp.push_back(1'b0);
        end else begin
            // Rise seen SS samples ago (sample SS+1 ago was still low).
            ev = samp[SS-1] && !samp[SS];
            m_tick = ev;
            m_exp  = 1'b0;
            // Counting (not held) this edge: was not paused last edge, or was just loaded.
            run_now = m_busy && (!prev_pause || prev_load);
            if (load) begin
                if (duration != 0) begin
                    m_rem = duration; m_busy = 1'b1;
                end else begin
                    m_rem = 0; m_busy = 1'b0; m_exp = 1'b1;
                end
            end else if (run_now && !pause && ev && m_rem >= 1) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 1'b0; m_exp = 1'b1;
                end
            end
            samp.push_front(clk_mstr);
            void'(samp.pop_back());
            prev_pause = pause;
            prev_load  = load;
        end
    endtask

    // One clock: update the model, let the DUT clock, compare away from the edge.
    task automatic step();
        model_edge();
        @(posedge clk_50_mhz);
        #1;
        chk("tick", tick, m_tick);
        chk("busy", busy, m_busy);
        chk("remaining", remaining, m_rem);
        chk("expired", expired, m_exp);
        if (tick) n_tick++;
        if (expired) n_exp++;
    endtask

    task automatic pulse_edge();
        clk_mstr = 1'b1;
        repeat (4) step();
        clk_mstr = 1'b0;
        repeat (4) step();
    endtask

    task automatic do_load(input int d);
        load = 1'b1;
        duration = SB'(d);
        step();
        load = 1'b0;
    endtask

    initial begin
        int lat;
        int hc;

        for (int i = 0; i <= SS; i++) samp.push_back(1'b0);

        // Reset state.
        reset_n = 1'b0;
        repeat (2) step();
        chk("rst_remaining", remaining, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        repeat (3) step();

        // Basic countdown of 3 s.
        do_load(3);
        chk("load3_rem", remaining, 3);
        chk("load3_busy", busy, 1);
        n_tick = 0; n_exp = 0;
        pulse_edge();
        chk("cd_rem2", remaining, 2);
        pulse_edge();
        chk("cd_rem1", remaining, 1);
        pulse_edge();
        chk("cd_rem0", remaining, 0);
        chk("cd_busy", busy, 0);
        chk("cd_ticks", n_tick, 3);
        chk("cd_expired", n_exp, 1);

        // Edge latency: the tick appears after the third sampling edge.
        repeat (10) step();
        clk_mstr = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            step();
            if (tick) lat = i;
        end
        chk("edge_latency", lat, 3);
        n_tick = 0;
        repeat (100) step();
        chk("held_high_ticks", n_tick, 0);
        clk_mstr = 1'b0;
        repeat (4) step();

        // Pause: edges are ignored, then the phase resumes.
        pause = 1'b1;
        do_load(2);
        step();
        repeat (5) pulse_edge();
        chk("pause_rem", remaining, 2);
        chk("pause_busy", busy, 1);
        pause = 1'b0;
        n_exp = 0;
        step();
        repeat (2) pulse_edge();
        chk("pause_expired", n_exp, 1);
        chk("pause_done_rem", remaining, 0);

        // Load in the same cycle as the final edge: reload wins, no expiry.
        do_load(1);
        clk_mstr = 1'b1;
        step();
        step();
        load = 1'b1; duration = SB'(5);
        step();
        load = 1'b0;
        chk("sim_rem", remaining, 5);
        chk("sim_expired", expired, 0);
        chk("sim_tick", tick, 1);
        clk_mstr = 1'b0;
        repeat (4) step();
        chk("sim_hold_rem", remaining, 5);

        // Zero-length load expires immediately.
        do_load(0);
        chk("zero_expired", expired, 1);
        chk("zero_busy", busy, 0);
        step();
        chk("zero_pulse_width", expired, 0);

        // Reset mid-phase discards the phase.
        do_load(4);
        repeat (2) pulse_edge();
        chk("mid_rem", remaining, 2);
        n_exp = 0;
        reset_n = 1'b0;
        step();
        chk("mr_rem", remaining, 0);
        chk("mr_busy", busy, 0);
        chk("mr_tick", tick, 0);
        reset_n = 1'b1;
        n_tick = 0;
        repeat (2) pulse_edge();
        chk("mr_ticks", n_tick, 2);
        chk("mr_expired", n_exp, 0);
        chk("mr_rem_after", remaining, 0);

        // Randomized traffic against the model.
        hc = 5;
        for (int c = 0; c < 4000; c++) begin
            hc--;
            if (hc == 0) begin
                clk_mstr = ~clk_mstr;
                hc = int'($urandom_range(3, 8));
            end
            load = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) duration = SB'($urandom_range(0, 63));
            else duration = SB'($urandom_range(0, 6));
            if ($urandom_range(0, 24) == 0) pause = ~pause;
            reset_n = ($urandom_range(0, 599) != 0);
            step();
        end
        reset_n = 1'b1;
        load = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
